// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// One bit per CLK cycle; TX_OUT and BUSY are registered.
module uart_tx_framer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_BIT,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  // Low until the first edge after reset release, so that edge cannot accept a word.
  logic                  armed;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      TX_OUT   <= 1'b1;
      BUSY     <= 1'b0;
      bit_cnt  <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (DATA_VALID && armed) begin
            state    <= START;
            data_q   <= P_DATA;
            par_en_q <= PAR_EN;
            TX_OUT   <= 1'b0;
            BUSY     <= 1'b1;
          end else begin
            TX_OUT <= 1'b1;
            BUSY   <= 1'b0;
          end
        end
        START: begin
          state   <= DATA;
          bit_cnt <= '0;
          TX_OUT  <= data_q[0];
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= PAR_BIT;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
          end else begin
            // Shift so the next bit to send is always at index 1 before this edge.
            bit_cnt <= bit_cnt + CNT_W'(1);
            data_q  <= {1'b0, data_q[DATA_WIDTH-1:1]};
            TX_OUT  <= data_q[1];
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
        end
        STOP: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer (widths 8 and 7); per-cycle {tx,busy} expectations
// are queued when a word is offered and popped on every clock.
module tb_uart_tx_framer;

  logic       clk;
  logic       rst;
  logic [7:0] pd8;
  logic       dv8, pe8, pb8;
  logic       tx8, busy8;
  logic [6:0] pd7;
  logic       dv7, pe7, pb7;
  logic       tx7, busy7;

  int n_cmp;
  int n_err;
  logic [1:0] q8[$];
  logic [1:0] q7[$];

  uart_tx_framer #(.DATA_WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .P_DATA(pd8), .DATA_VALID(dv8),
    .PAR_EN(pe8), .PAR_BIT(pb8), .TX_OUT(tx8), .BUSY(busy8)
  );

  uart_tx_framer #(.DATA_WIDTH(7)) dut7 (
    .CLK(clk), .RST(rst), .P_DATA(pd7), .DATA_VALID(dv7),
    .PAR_EN(pe7), .PAR_BIT(pb7), .TX_OUT(tx7), .BUSY(busy7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic act, input logic exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, act, exp);
    end
  endtask

  // Expected line activity for one frame, ending with the single idle cycle after it.
  task automatic push_frame(input int w, input logic [8:0] d, input logic pe, input logic pb);
    logic [1:0] e[$];
    e.push_back(2'b01);
    for (int i = 0; i < w; i++) e.push_back({d[i], 1'b1});
    if (pe) e.push_back({pb, 1'b1});
    e.push_back(2'b11);
    e.push_back(2'b10);
    foreach (e[k]) begin
      if (w == 8) q8.push_back(e[k]);
      else        q7.push_back(e[k]);
    end
  endtask

  task automatic sample();
    logic [1:0] e8, e7;
    e8 = (q8.size() > 0) ? q8.pop_front() : 2'b10;
    e7 = (q7.size() > 0) ? q7.pop_front() : 2'b10;
    chk("tx8",   tx8,   e8[1]);
    chk("busy8", busy8, e8[0]);
    chk("tx7",   tx7,   e7[1]);
    chk("busy7", busy7, e7[0]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    pd8 = '0; dv8 = 1'b0; pe8 = 1'b0; pb8 = 1'b0;
    pd7 = '0; dv7 = 1'b0; pe7 = 1'b0; pb7 = 1'b0;

    // Reset state
    #12;
    chk("rst_tx", tx8, 1'b1);
    chk("rst_busy", busy8, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();

    // 0xA5 without parity, 1-cycle DATA_VALID
    pd8 = 8'hA5; pe8 = 1'b0; dv8 = 1'b1;
    push_frame(8, 9'h0A5, 1'b0, 1'b0);
    step();
    dv8 = 1'b0;
    repeat (12) step();

    // 0xA5 with even parity bit 0
    pd8 = 8'hA5; pe8 = 1'b1; pb8 = 1'b0; dv8 = 1'b1;
    push_frame(8, 9'h0A5, 1'b1, 1'b0);
    step();
    dv8 = 1'b0;
    repeat (13) step();

    // 0x01 with parity 1; inputs change after capture
    pd8 = 8'h01; pe8 = 1'b1; pb8 = 1'b1; dv8 = 1'b1;
    push_frame(8, 9'h001, 1'b1, 1'b1);
    step();
    dv8 = 1'b0;
    step();
    pd8 = 8'hFF; pe8 = 1'b0;
    repeat (12) step();
    pb8 = 1'b0;

    // DATA_VALID held high: two back-to-back frames with one idle cycle each
    pd8 = 8'h3C; pe8 = 1'b0; dv8 = 1'b1;
    push_frame(8, 9'h03C, 1'b0, 1'b0);
    push_frame(8, 9'h03C, 1'b0, 1'b0);
    repeat (22) step();
    dv8 = 1'b0;
    repeat (3) step();

    // DATA_VALID pulse while busy must not start another frame
    dv8 = 1'b1;
    push_frame(8, 9'h03C, 1'b0, 1'b0);
    step();
    dv8 = 1'b0;
    repeat (3) step();
    pd8 = 8'hFF;
    dv8 = 1'b1;
    step();
    dv8 = 1'b0;
    repeat (10) step();

    // Reset in DATA cycle 4 of 0xFF aborts the frame asynchronously
    pd8 = 8'hFF; pe8 = 1'b0; dv8 = 1'b1;
    push_frame(8, 9'h0FF, 1'b0, 1'b0);
    step();
    dv8 = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    #1;
    chk("abort_tx", tx8, 1'b1);
    chk("abort_busy", busy8, 1'b0);
    q8.delete();
    step();
    step();

    // Release coincident with an edge while DATA_VALID is high: not accepted there
    pd8 = 8'h00; dv8 = 1'b1;
    @(posedge clk);
    rst = 1'b1;
    #1;
    sample();
    push_frame(8, 9'h000, 1'b0, 1'b0);
    step();
    dv8 = 1'b0;
    repeat (12) step();

    // DATA_WIDTH=7, 0x55 without parity
    pd7 = 7'h55; pe7 = 1'b0; dv7 = 1'b1;
    push_frame(7, 9'h055, 1'b0, 1'b0);
    step();
    dv7 = 1'b0;
    repeat (10) step();

    if (q8.size() != 0 || q7.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL drain: observed %0d/%0d entries left expected 0", q8.size(), q7.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
